// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, shifts out one command byte
// with odd parity, then reports the device ACK/NACK or a clock timeout.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       data_reg, data_next;
    logic             parity_reg, parity_next;
    logic [3:0]       bit_idx_reg, bit_idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ack_ok_reg, ack_ok_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic             data_oe_reg, data_oe_next;

    // bit 0 = PS2_CLK, bit 1 = PS2_DATA; reset to the idle (released) level
    logic [1:0] meta_reg, sync_reg;
    logic       clk_prev_reg;
    logic       sync_clk, sync_data, fe, timed_out;
    logic [9:0] frame_bits;

    assign sync_clk   = sync_reg[0];
    assign sync_data  = sync_reg[1];
    assign fe         = clk_prev_reg & ~sync_clk;
    assign timed_out  = (cnt_reg == TO_LAST);
    assign frame_bits = {1'b1, parity_reg, data_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg     <= 2'b11;
            sync_reg     <= 2'b11;
            clk_prev_reg <= 1'b1;
            state_reg    <= S_IDLE;
            data_reg     <= 8'h00;
            parity_reg   <= 1'b0;
            bit_idx_reg  <= 4'd0;
            cnt_reg      <= '0;
            ack_ok_reg   <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            data_oe_reg  <= 1'b0;
        end else begin
            meta_reg     <= {ps2_data_in, ps2_clk_in};
            sync_reg     <= meta_reg;
            clk_prev_reg <= sync_clk;
            state_reg    <= state_next;
            data_reg     <= data_next;
            parity_reg   <= parity_next;
            bit_idx_reg  <= bit_idx_next;
            cnt_reg      <= cnt_next;
            ack_ok_reg   <= ack_ok_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            data_oe_reg  <= data_oe_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        parity_next  = parity_reg;
        bit_idx_next = bit_idx_reg;
        cnt_next     = cnt_reg;
        ack_ok_next  = ack_ok_reg;
        done_next    = 1'b0;
        error_next   = 1'b0;
        data_oe_next = data_oe_reg;

        case (state_reg)
            S_IDLE: begin
                data_oe_next = 1'b0;
                if (tx_valid && tx_ready) begin
                    data_next   = tx_data;
                    parity_next = ~^tx_data;
                    ack_ok_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_reg == INH_LAST) begin
                    cnt_next   = '0;
                    state_next = S_START;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_START: begin
                // start bit stays on the line until the device's first falling edge
                data_oe_next = 1'b1;
                bit_idx_next = 4'd0;
                cnt_next     = '0;
                state_next   = S_SHIFT;
            end
            S_SHIFT: begin
                if (fe) begin
                    data_oe_next = ~frame_bits[bit_idx_reg];
                    cnt_next     = '0;
                    if (bit_idx_reg == 4'd9) begin
                        state_next = S_ACK;
                    end else begin
                        bit_idx_next = bit_idx_reg + 4'd1;
                    end
                end else if (timed_out) begin
                    data_oe_next = 1'b0;
                    ack_ok_next  = 1'b0;
                    error_next   = 1'b1;
                    state_next   = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_ACK: begin
                data_oe_next = 1'b0;
                if (fe) begin
                    ack_ok_next = ~sync_data;
                    cnt_next    = '0;
                    state_next  = S_RELEASE;
                end else if (timed_out) begin
                    ack_ok_next = 1'b0;
                    error_next  = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_RELEASE: begin
                data_oe_next = 1'b0;
                if (sync_clk && sync_data) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else if (fe) begin
                    cnt_next = '0;
                end else if (timed_out) begin
                    ack_ok_next = 1'b0;
                    error_next  = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                data_oe_next = 1'b0;
                state_next   = S_IDLE;
            end
        endcase
    end

    assign tx_ready    = (state_reg == S_IDLE);
    assign busy        = ~tx_ready;
    assign done        = done_reg;
    assign error       = error_reg;
    assign ack_ok      = ack_ok_reg;
    assign ps2_clk_oe  = (state_reg == S_INHIBIT) || (state_reg == S_START);
    assign ps2_data_oe = (state_reg == S_START) || ((state_reg == S_SHIFT) && data_oe_reg);

endmodule
